imc_instr_sequencer: RTL and testbench

Buffers in-memory-compute instructions from the host and issues them one at a time to imc_decoder. Each instruction is held stable on the decoder's instruction input for a class-dependent number of cycles (MIG, MAGIC, IMPLY, BITWISE). A single NOP gap cycle follows each instruction. Sits between the host/instruction source and imc_decoder.

---
 rtl/imc_pkg.sv | 26 ++
 rtl/imc_instr_fifo.sv | 58 +++++
 rtl/imc_instr_sequencer.sv | 171 +++++++++++++++++
 tb/tb_imc_instr_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imc_pkg.sv
// Shared constants for the IMC instruction sequencer.
// Covers class encodings, NOP word, FSM states and default hold times.
package imc_pkg;

  localparam logic [1:0] IMC_CLS_IMPLY   = 2'b00;
  localparam logic [1:0] IMC_CLS_MAGIC   = 2'b01;
  localparam logic [1:0] IMC_CLS_MIG     = 2'b10;
  localparam logic [1:0] IMC_CLS_BITWISE = 2'b11;

  localparam int IMC_CLS_MSB = 31;
  localparam int IMC_CLS_LSB = 30;

  localparam int IMC_NOP = 0;

  localparam int IMC_MIG_CYC     = 3;
  localparam int IMC_MAGIC_CYC   = 2;
  localparam int IMC_IMPLY_CYC   = 4;
  localparam int IMC_BITWISE_CYC = 2;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    GAP
  } imc_state_e;

endpackage

// File: rtl/imc_instr_fifo.sv
// Synchronous instruction FIFO with flush, occupancy count and flags.
// No bypass: a push while full is refused even if a pop happens.
module imc_instr_fifo
  import imc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/imc_instr_sequencer.sv
// Issues queued IMC instructions to imc_decoder with class-based hold + NOP gap.
// Optional IMC_SEQ_PERF_EN adds saturating issue/stall counters.
module imc_instr_sequencer
  import imc_pkg::*;
#(
  parameter int INSTRUCTION_SIZE = 32,
  parameter int DEPTH            = 4,
  parameter int MIG_CYC          = IMC_MIG_CYC,
  parameter int MAGIC_CYC        = IMC_MAGIC_CYC,
  parameter int IMPLY_CYC        = IMC_IMPLY_CYC,
  parameter int BITWISE_CYC      = IMC_BITWISE_CYC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INSTRUCTION_SIZE-1:0]   in_instr,
  output logic [INSTRUCTION_SIZE-1:0]   dec_instr,
  output logic                          dec_valid,
  output logic [1:0]                    op_class,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(DEPTH+1)-1:0]    fifo_count
`ifdef IMC_SEQ_PERF_EN
  ,
  output logic [15:0]                   perf_issued,
  output logic [15:0]                   perf_stall
`endif
);

  localparam int IW = INSTRUCTION_SIZE;

  imc_state_e      state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [IW-1:0]   dec_instr_q, dec_instr_d;
  logic            dec_valid_q, dec_valid_d;
  logic [1:0]      op_class_q, op_class_d;
  logic            done_q, done_d;

  logic            push;
  logic            pop;
  logic            load;
  logic            full;
  logic            empty;
  logic [IW-1:0]   rdata;
  logic [1:0]      rcls;

  // Zero-cycle hold settings still occupy the decoder for one cycle.
  function automatic logic [15:0] hold_m1(input logic [1:0] cls);
    int n;
    n = 1;
    unique case (1'b1)
      (cls == IMC_CLS_IMPLY):   n = IMPLY_CYC;
      (cls == IMC_CLS_MAGIC):   n = MAGIC_CYC;
      (cls == IMC_CLS_MIG):     n = MIG_CYC;
      (cls == IMC_CLS_BITWISE): n = BITWISE_CYC;
    endcase
    if (n < 1) n = 1;
    return 16'(n - 1);
  endfunction

  assign in_ready = rst && !full && !flush;
  assign push     = in_valid && in_ready;
  assign rcls     = rdata[IMC_CLS_MSB:IMC_CLS_LSB];

  imc_instr_fifo #(
    .WIDTH (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_instr),
    .rdata_o (rdata),
    .count_o (fifo_count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dec_instr_d = dec_instr_q;
    dec_valid_d = dec_valid_q;
    op_class_d  = op_class_q;
    done_d      = 1'b0;
    load        = 1'b0;
    pop         = 1'b0;
    if (flush) begin
      state_d     = IDLE;
      dec_instr_d = IW'(IMC_NOP);
      dec_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: load = !empty;
        EXEC: begin
          if (cnt_q == '0) begin
            state_d     = GAP;
            dec_instr_d = IW'(IMC_NOP);
            dec_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        GAP: begin
          load = !empty;
          if (empty) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (load) begin
        pop         = 1'b1;
        state_d     = EXEC;
        cnt_d       = hold_m1(rcls);
        dec_instr_d = rdata;
        dec_valid_d = 1'b1;
        op_class_d  = rcls;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dec_instr_q <= '0;
      dec_valid_q <= 1'b0;
      op_class_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dec_instr_q <= dec_instr_d;
      dec_valid_q <= dec_valid_d;
      op_class_q  <= op_class_d;
      done_q      <= done_d;
    end
  end

  assign dec_instr = dec_instr_q;
  assign dec_valid = dec_valid_q;
  assign op_class  = op_class_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE) || !empty;

`ifdef IMC_SEQ_PERF_EN
  logic [15:0] issued_q;
  logic [15:0] stall_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (pop && issued_q != 16'hFFFF)
        issued_q <= issued_q + 16'd1;
      if (in_valid && !in_ready && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_imc_instr_sequencer.sv
// Directed bench for imc_instr_sequencer, incl. IMPLY_CYC=0 instance.
// Define IMC_SEQ_PERF_EN to also check the perf counters.
module tb_imc_instr_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready;
  logic [31:0] in_instr, dec_instr;
  logic        dec_valid, busy, done;
  logic [1:0]  op_class;
  logic [2:0]  fifo_count;

  logic        flush2, iv2, ir2, dv2, busy2, done2;
  logic [31:0] ii2, di2;
  logic [1:0]  oc2;
  logic [2:0]  fc2;

`ifdef IMC_SEQ_PERF_EN
  logic [15:0] perf_issued, perf_stall, pi2, ps2;
`endif

  imc_instr_sequencer u_dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .dec_instr  (dec_instr),
    .dec_valid  (dec_valid),
    .op_class   (op_class),
    .busy       (busy),
    .done       (done),
    .fifo_count (fifo_count)
`ifdef IMC_SEQ_PERF_EN
    ,
    .perf_issued(perf_issued),
    .perf_stall (perf_stall)
`endif
  );

  imc_instr_sequencer #(.IMPLY_CYC(0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush2),
    .in_valid   (iv2),
    .in_ready   (ir2),
    .in_instr   (ii2),
    .dec_instr  (di2),
    .dec_valid  (dv2),
    .op_class   (oc2),
    .busy       (busy2),
    .done       (done2),
    .fifo_count (fc2)
`ifdef IMC_SEQ_PERF_EN
    ,
    .perf_issued(pi2),
    .perf_stall (ps2)
`endif
  );

  int nvec = 0;
  int nerr = 0;

  logic [31:0] vi [12];
  int          vn [12];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect entries lo..hi issued back-to-back, starting at the next edge.
  task automatic issue(input int lo, input int hi);
    logic [31:0] w;
    for (int i = lo; i <= hi; i++) begin
      w = vi[i];
      for (int j = 0; j < vn[i]; j++) begin
        tick();
        chk("exec_valid", 32'(dec_valid), 1);
        chk("exec_instr", dec_instr, w);
        chk("exec_class", 32'(op_class), 32'(w[31:30]));
        chk("exec_done", 32'(done), 0);
      end
      tick();
      chk("gap_valid", 32'(dec_valid), 0);
      chk("gap_instr", dec_instr, 0);
      chk("gap_done", 32'(done), 1);
    end
  endtask

  initial begin
    vi[0]  = 32'h83000000; vn[0]  = 3;
    vi[1]  = 32'hB81E0000; vn[1]  = 3;
    vi[2]  = 32'hF81E0000; vn[2]  = 2;
    vi[3]  = 32'h1A800000; vn[3]  = 4;
    vi[4]  = 32'h38000000; vn[4]  = 4;
    for (int i = 0; i < 6; i++) begin
      vi[5+i] = 32'h0A000001 + 32'(i);
      vn[5+i] = 4;
    end
    vi[11] = 32'h83000007; vn[11] = 3;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
    flush2 = 1'b0; iv2 = 1'b0; ii2 = '0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_valid", 32'(dec_valid), 0);
    chk("rst_instr", dec_instr, 0);
    chk("rst_class", 32'(op_class), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 1);

    // single MIG
    in_valid = 1'b1; in_instr = vi[0];
    tick();
    in_valid = 1'b0;
    chk("t1_count", 32'(fifo_count), 1);
    chk("t1_valid_early", 32'(dec_valid), 0);
    chk("t1_busy", 32'(busy), 1);
    issue(0, 0);
    tick();
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_done", 32'(done), 0);

    // back-to-back mix
    fork
      begin
        for (int i = 1; i <= 4; i++) begin
          in_valid = 1'b1; in_instr = vi[i];
          tick();
        end
        in_valid = 1'b0;
      end
      begin
        tick();
        issue(1, 4);
      end
    join
    tick();
    chk("t2_busy", 32'(busy), 0);

    // six pushes with in_valid held; refused before edges 6 and 7
    fork
      begin
        for (int e = 0; e < 8; e++) begin
          in_valid = 1'b1;
          in_instr = vi[5 + ((e < 5) ? e : 5)];
          chk("t3_in_ready", 32'(in_ready), (e == 5 || e == 6) ? 0 : 1);
          tick();
          if (e == 4) chk("t3_count_full", 32'(fifo_count), 4);
        end
        in_valid = 1'b0;
      end
      begin
        tick();
        issue(5, 10);
      end
    join
    tick();
    chk("t3_busy", 32'(busy), 0);
`ifdef IMC_SEQ_PERF_EN
    chk("t3_perf_issued", 32'(perf_issued), 11);
    chk("t3_perf_stall", 32'(perf_stall), 2);
`endif

    // flush during 2nd EXEC cycle of a MIG op with 2 queued
    in_valid = 1'b1; in_instr = 32'h83000001;
    tick();
    in_instr = 32'h40000002;
    tick();
    chk("t4_valid1", 32'(dec_valid), 1);
    chk("t4_instr1", dec_instr, 32'h83000001);
    in_instr = 32'h40000003;
    tick();
    chk("t4_valid2", 32'(dec_valid), 1);
    chk("t4_count2", 32'(fifo_count), 2);
    flush = 1'b1; in_instr = 32'h40000004;
    #1;
    chk("t4_flush_ready", 32'(in_ready), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_valid", 32'(dec_valid), 0);
    chk("t4_instr", dec_instr, 0);
    chk("t4_count", 32'(fifo_count), 0);
    chk("t4_done", 32'(done), 0);
    chk("t4_busy", 32'(busy), 0);
    tick();
    chk("t4_done_after", 32'(done), 0);
    chk("t4_valid_after", 32'(dec_valid), 0);
    chk("t4_count_after", 32'(fifo_count), 0);

    // reset mid-EXEC with one queued
    in_valid = 1'b1; in_instr = 32'h40000005;
    tick();
    in_instr = 32'h40000006;
    tick();
    in_valid = 1'b0;
    chk("t5_valid", 32'(dec_valid), 1);
    chk("t5_count", 32'(fifo_count), 1);
    rst = 1'b0;
    tick();
    chk("t5_rst_valid", 32'(dec_valid), 0);
    chk("t5_rst_instr", dec_instr, 0);
    chk("t5_rst_class", 32'(op_class), 0);
    chk("t5_rst_done", 32'(done), 0);
    chk("t5_rst_count", 32'(fifo_count), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_ready", 32'(in_ready), 0);
    rst = 1'b1;
    tick();
    chk("t5_post_done", 32'(done), 0);
    chk("t5_post_valid", 32'(dec_valid), 0);
    in_valid = 1'b1; in_instr = vi[11];
    tick();
    in_valid = 1'b0;
    issue(11, 11);
    tick();
    chk("t5_busy", 32'(busy), 0);
`ifdef IMC_SEQ_PERF_EN
    chk("t5_perf_issued", 32'(perf_issued), 1);
    chk("t5_perf_stall", 32'(perf_stall), 0);
`endif

    // IMPLY_CYC=0 instance holds an IMPLY op for one cycle
    iv2 = 1'b1; ii2 = 32'h1A800000;
    tick();
    iv2 = 1'b0;
    tick();
    chk("t6_valid", 32'(dv2), 1);
    chk("t6_instr", di2, 32'h1A800000);
    chk("t6_class", 32'(oc2), 0);
    tick();
    chk("t6_gap_valid", 32'(dv2), 0);
    chk("t6_gap_done", 32'(done2), 1);
    chk("t6_gap_instr", di2, 0);
    tick();
    chk("t6_busy", 32'(busy2), 0);
    chk("t6_done_lo", 32'(done2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
